regfile_bypass: RTL and testbench

REGFILE_BYPASS -- requirements
Module: regfile_bypass

---
 rtl/regfile_pkg.sv | 20 ++
 rtl/regfile_sb.sv | 57 +++++
 rtl/regfile_bypass.sv | 83 ++++++++
 tb/tb_regfile_bypass.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared defaults and address-width derivation for the bypassing register file.
package regfile_pkg;

    localparam int unsigned XLEN_DEF = 32;
    localparam int unsigned NREG_DEF = 32;
    localparam int unsigned NRP_DEF  = 2;

    // Number of address bits needed to name n registers (n is a power of two, >= 2).
    function automatic int unsigned addr_width(input int unsigned n);
        int unsigned w;
        w = 1;
        for (int unsigned i = 1; i < 32; i++) begin
            if ((32'd1 << i) < n) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/regfile_sb.sv
// Pending-producer scoreboard: one bit per register, cleared by writes, set by issue.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int unsigned NREG = NREG_DEF,
    parameter int unsigned NRP  = NRP_DEF,
    localparam int unsigned AW  = addr_width(NREG)
) (
    input  logic              clk,
    input  logic              res,
    input  logic              sb_set,
    input  logic [AW-1:0]     sb_addr,
    input  logic [1:0]        we,
    input  logic [2*AW-1:0]   wa,
    input  logic [NRP*AW-1:0] ra,
    output logic [NRP-1:0]    busy,
    output logic [NREG-1:0]   busy_vec
);

    logic [NREG-1:0] bits_q, bits_d;
    logic [NREG-1:0] clr;

    // Clearing writes, then a new producer, which wins over a same-cycle clear.
    always_comb begin
        clr = '0;
        for (int k = 0; k < 2; k++) begin
            if (we[k]) begin
                clr[wa[k*AW +: AW]] = 1'b1;
            end
        end
        clr[0] = 1'b0;
        bits_d = bits_q & ~clr;
        if (sb_set) begin
            bits_d[sb_addr] = 1'b1;
        end
        bits_d[0] = 1'b0;
    end

    // Scoreboard state register.
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            bits_q <= '0;
        end else begin
            bits_q <= bits_d;
        end
    end

    // A write landing this cycle already resolves the hazard for the reader.
    always_comb begin
        for (int i = 0; i < NRP; i++) begin
            busy[i] = bits_q[ra[i*AW +: AW]] & ~clr[ra[i*AW +: AW]];
        end
    end

    assign busy_vec = bits_q;

endmodule

// File: rtl/regfile_bypass.sv
// Flop-based register file with two write ports, write-first bypass and registered reads.
module regfile_bypass
    import regfile_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_DEF,
    parameter int unsigned NREG = NREG_DEF,
    parameter int unsigned NRP  = NRP_DEF,
    localparam int unsigned AW  = addr_width(NREG)
) (
    input  logic                clk,
    input  logic                res,
    input  logic [NRP-1:0]      rd_en,
    input  logic [NRP*AW-1:0]   ra,
    output logic [NRP*XLEN-1:0] rd,
    output logic [NRP-1:0]      busy,
    input  logic [1:0]          we,
    input  logic [2*AW-1:0]     wa,
    input  logic [2*XLEN-1:0]   wd,
    input  logic                sb_set,
    input  logic [AW-1:0]       sb_addr,
    output logic [NREG-1:0]     busy_vec
);

    logic [XLEN-1:0]     regs_q [NREG];
    logic [XLEN-1:0]     regs_d [NREG];
    logic [NRP*XLEN-1:0] rd_q, rd_d;

    // Post-write register image; port 1 applied last so it wins a same-address collision.
    always_comb begin
        for (int r = 0; r < NREG; r++) begin
            regs_d[r] = regs_q[r];
        end
        for (int k = 0; k < 2; k++) begin
            if (we[k]) begin
                regs_d[wa[k*AW +: AW]] = wd[k*XLEN +: XLEN];
            end
        end
        regs_d[0] = '0;
    end

    // Reading the post-write image gives write-first bypass for free.
    always_comb begin
        rd_d = rd_q;
        for (int i = 0; i < NRP; i++) begin
            if (rd_en[i]) begin
                rd_d[i*XLEN +: XLEN] = regs_d[ra[i*AW +: AW]];
            end
        end
    end

    // Storage and read-data registers.
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            for (int r = 0; r < NREG; r++) begin
                regs_q[r] <= '0;
            end
            rd_q <= '0;
        end else begin
            for (int r = 0; r < NREG; r++) begin
                regs_q[r] <= regs_d[r];
            end
            rd_q <= rd_d;
        end
    end

    assign rd = rd_q;

    regfile_sb #(
        .NREG (NREG),
        .NRP  (NRP)
    ) u_sb (
        .clk      (clk),
        .res      (res),
        .sb_set   (sb_set),
        .sb_addr  (sb_addr),
        .we       (we),
        .wa       (wa),
        .ra       (ra),
        .busy     (busy),
        .busy_vec (busy_vec)
    );

endmodule

// File: tb/tb_regfile_bypass.sv
// Self-checking bench: reference model feeds an expected-read queue, popped after each edge.
module tb_regfile_bypass;

    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int NRP  = 2;
    localparam int AW   = 5;

    logic                clk = 1'b0;
    logic                res;
    logic [NRP-1:0]      rd_en;
    logic [NRP*AW-1:0]   ra;
    logic [NRP*XLEN-1:0] rd;
    logic [NRP-1:0]      busy;
    logic [1:0]          we;
    logic [2*AW-1:0]     wa;
    logic [2*XLEN-1:0]   wd;
    logic                sb_set;
    logic [AW-1:0]       sb_addr;
    logic [NREG-1:0]     busy_vec;

    always #5 clk = ~clk;

    regfile_bypass #(
        .XLEN (XLEN),
        .NREG (NREG),
        .NRP  (NRP)
    ) dut (
        .clk      (clk),
        .res      (res),
        .rd_en    (rd_en),
        .ra       (ra),
        .rd       (rd),
        .busy     (busy),
        .we       (we),
        .wa       (wa),
        .wd       (wd),
        .sb_set   (sb_set),
        .sb_addr  (sb_addr),
        .busy_vec (busy_vec)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model state
    logic [XLEN-1:0] m_regs [NREG];
    logic [NREG-1:0] m_sb;
    logic [XLEN-1:0] m_rd   [NRP];
    logic [XLEN-1:0] exp_q  [$];

    task automatic model_reset();
        for (int r = 0; r < NREG; r++) m_regs[r] = '0;
        for (int p = 0; p < NRP; p++) m_rd[p] = '0;
        m_sb = '0;
    endtask

    task automatic idle();
        rd_en = '0; ra = '0; we = '0; wa = '0; wd = '0; sb_set = 1'b0; sb_addr = '0;
    endtask

    task automatic set_rd(input int p, input logic en, input logic [AW-1:0] a);
        rd_en[p] = en;
        ra[p*AW +: AW] = a;
    endtask

    task automatic set_wr(input int k, input logic en, input logic [AW-1:0] a,
                          input logic [XLEN-1:0] d);
        we[k] = en;
        wa[k*AW +: AW] = a;
        wd[k*XLEN +: XLEN] = d;
    endtask

    // One clock with the currently driven inputs: check busy, predict, clock, compare.
    task automatic cycle();
        logic [XLEN-1:0] nregs [NREG];
        logic [NREG-1:0] clr;
        logic [AW-1:0]   a;
        #1;
        clr = '0;
        for (int k = 0; k < 2; k++) begin
            a = wa[k*AW +: AW];
            if (we[k] && a != 0) clr[a] = 1'b1;
        end
        for (int p = 0; p < NRP; p++) begin
            a = ra[p*AW +: AW];
            check($sformatf("busy%0d_r%0d", p, a), 64'(busy[p]), 64'(m_sb[a] && !clr[a]));
        end
        nregs = m_regs;
        for (int k = 0; k < 2; k++) begin
            a = wa[k*AW +: AW];
            if (we[k] && a != 0) nregs[a] = wd[k*XLEN +: XLEN];
        end
        for (int p = 0; p < NRP; p++) begin
            a = ra[p*AW +: AW];
            if (rd_en[p]) m_rd[p] = nregs[a];
            exp_q.push_back(m_rd[p]);
        end
        m_regs = nregs;
        m_sb = m_sb & ~clr;
        if (sb_set && sb_addr != 0) m_sb[sb_addr] = 1'b1;
        @(posedge clk);
        #1;
        for (int p = 0; p < NRP; p++) begin
            check($sformatf("rd%0d", p), 64'(rd[p*XLEN +: XLEN]), 64'(exp_q.pop_front()));
        end
        check("busy_vec", 64'(busy_vec), 64'(m_sb));
    endtask

    initial begin
        idle();
        model_reset();
        res = 1'b0;
        #12;
        check("reset_rd", 64'(rd), 64'd0);
        check("reset_busy_vec", 64'(busy_vec), 64'd0);
        res = 1'b1;

        // Sweep all addresses on both ports after reset
        for (int i = 0; i < NREG; i++) begin
            set_rd(0, 1'b1, AW'(i));
            set_rd(1, 1'b1, AW'(NREG - 1 - i));
            cycle();
            check("sweep_rd", 64'(rd), 64'd0);
        end

        // Write-first bypass on r5, and r0 stays zero
        idle();
        set_wr(0, 1'b1, 5'd5, 32'hDEADBEEF);
        set_rd(1, 1'b1, 5'd5);
        cycle();
        check("bypass_r5", 64'(rd[XLEN +: XLEN]), 64'hDEADBEEF);
        idle();
        set_wr(0, 1'b1, 5'd0, 32'h1234);
        set_rd(0, 1'b1, 5'd0);
        cycle();
        check("r0_same_cycle", 64'(rd[0 +: XLEN]), 64'd0);
        idle();
        set_rd(0, 1'b1, 5'd0);
        cycle();
        check("r0_after", 64'(rd[0 +: XLEN]), 64'd0);

        // Dual write to r7: port 1 wins
        idle();
        set_wr(0, 1'b1, 5'd7, 32'h11111111);
        set_wr(1, 1'b1, 5'd7, 32'h22222222);
        set_rd(0, 1'b1, 5'd7);
        cycle();
        check("r7_bypass", 64'(rd[0 +: XLEN]), 64'h22222222);
        idle();
        set_rd(1, 1'b1, 5'd7);
        cycle();
        check("r7_stored", 64'(rd[XLEN +: XLEN]), 64'h22222222);

        // Scoreboard on r9
        idle();
        sb_set = 1'b1; sb_addr = 5'd9;
        cycle();
        check("sb9_set", 64'(busy_vec[9]), 64'd1);
        idle();
        set_rd(0, 1'b1, 5'd9);
        #1;
        check("busy9_pending", 64'(busy[0]), 64'd1);
        set_wr(1, 1'b1, 5'd9, 32'hCAFE0009);
        #1;
        check("busy9_clearing", 64'(busy[0]), 64'd0);
        cycle();
        check("sb9_cleared", 64'(busy_vec[9]), 64'd0);
        idle();
        sb_set = 1'b1; sb_addr = 5'd9;
        set_wr(0, 1'b1, 5'd9, 32'h99);
        cycle();
        check("sb9_set_wins", 64'(busy_vec[9]), 64'd1);
        idle();
        sb_set = 1'b1; sb_addr = 5'd0;
        cycle();
        check("sb0_ignored", 64'(busy_vec[0]), 64'd0);

        // Read hold while rd_en is low
        idle();
        set_wr(0, 1'b1, 5'd3, 32'hA5A5_0003);
        cycle();
        idle();
        set_rd(0, 1'b1, 5'd3);
        cycle();
        for (int i = 0; i < 3; i++) begin
            idle();
            set_rd(0, 1'b0, 5'd3);
            set_wr(i % 2, 1'b1, 5'd3, 32'h3000 + i);
            cycle();
            check("hold_r3", 64'(rd[0 +: XLEN]), 64'hA5A5_0003);
        end

        // Asynchronous reset in the middle of a write burst
        idle();
        set_wr(0, 1'b1, 5'd12, 32'h1200_0000);
        set_wr(1, 1'b1, 5'd13, 32'h1300_0000);
        set_rd(0, 1'b1, 5'd12);
        set_rd(1, 1'b1, 5'd3);
        sb_set = 1'b1; sb_addr = 5'd14;
        #1;
        res = 1'b0;
        #1;
        check("rst_rd_now", 64'(rd), 64'd0);
        check("rst_busy_vec_now", 64'(busy_vec), 64'd0);
        check("rst_busy_now", 64'(busy), 64'd0);
        @(posedge clk);
        #1;
        check("rst_rd_held", 64'(rd), 64'd0);
        check("rst_busy_vec_held", 64'(busy_vec), 64'd0);
        model_reset();
        res = 1'b1;
        idle();
        set_rd(0, 1'b1, 5'd12);
        set_rd(1, 1'b1, 5'd13);
        cycle();
        check("rst_no_commit", 64'(rd), 64'd0);
        set_rd(0, 1'b1, 5'd3);
        set_rd(1, 1'b1, 5'd7);
        cycle();

        // Random traffic against the model
        for (int i = 0; i < 200; i++) begin
            rd_en   = NRP'($urandom);
            ra      = NRP*AW'($urandom);
            we      = 2'($urandom);
            wa      = (2*AW)'($urandom);
            wd      = {$urandom, $urandom};
            sb_set  = 1'($urandom);
            sb_addr = AW'($urandom);
            if (i % 7 == 0) wa[2*AW-1:AW] = wa[AW-1:0];
            if (i % 5 == 0) ra[AW-1:0] = wa[AW-1:0];
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
